four_state_stim_gen: RTL and testbench
======================================

# four_state_stim_gen

Seeded stimulus source that emits bursts of 4-state (0/1/x/z) vectors over a valid/ready handshake. It sits directly upstream of the generated modules under test and drives their input ports, like the multi-dimensional `logic`/`tri1` inputs, with reproducible x/z-laden patterns. Each burst is fully determined by a two-word seed, and the block reports the seed it ends on so runs can be chained and replayed.

## Interface
- `WIDTH`, default 8: bits per emitted vector; legal range 1..16.
- `COUNT`, default 16: vectors per burst; must be at least 1.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: begins a burst when the block is IDLE; ignored otherwise.
- `seed_a`  in  64: initial generator state; sampled with `start`.
- `seed_b`  in  64: increment word; sampled with `start`, stored with bit 0 forced to 1.
- `out_valid`  out  1: the vector on `out_val`/`out_unk` is valid.
- `out_ready`  in  1: the downstream block accepts the vector.
- `out_val`  out  WIDTH: value plane.
- `out_unk`  out  WIDTH: unknown plane. Encoding per bit (`unk`,`val`): 00=0, 01=1, 10=z, 11=x.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse after the last handshake of a burst.
- `seed_after_a`  out  64: generator state after the burst.
- `seed_after_b`  out  64: stored increment word (odd).

## Operation
- Reset: state IDLE, generator state 0, increment 1, count 0. All outputs are 0, including `out_valid`, `busy`, `done`, `out_val`, `out_unk` and both seed_after words.
- State machine:
  - IDLE: on `start`, load state s=`seed_a`, b=`seed_b`|1, count=0, then go to RUN.
  - RUN: on each handshake, advance s, increment count, and leave RUN when count reaches COUNT.
  - DONE: lasts one cycle, then returns to IDLE.
- Vector mapping is combinational from registered s:
  - `out_val` = s[WIDTH-1:0].
  - `out_unk` = s[32+:WIDTH] & s[48+:WIDTH], giving roughly 25% unknown density.
  - Both are 0 outside RUN.
- Advance: t=s^(s<<13); t=t^(t>>7); t=t^(t<<17); s_next=t+b. All arithmetic is mod 2^64.
  - The odd b guarantees no lock-up at s=0.
- Handshake: a transfer happens when `out_valid`&&`out_ready` at a rising edge.
  - While `out_valid` is high and `out_ready` is low, `out_val`/`out_unk` hold stable.
  - `out_valid` never drops without a transfer, except on `rst`.
- On the final transfer (count becomes COUNT), the next state is DONE.
  - In DONE, `done`=1, `busy`=0, `out_valid`=0.
  - `seed_after_a`=s_next of the final advance; `seed_after_b`=b.
  - The seed_after words are held until the next `start` is accepted.
- `start` arriving in RUN or DONE is ignored entirely: seeds are not resampled and no burst is queued.
- `out_ready` has no effect outside RUN.

## Timing
- `start` sampled at edge N gives `busy`=1 and `out_valid`=1 after edge N, with the vector from `seed_a`.
- With `out_ready` tied high: one vector per cycle.
  - The final transfer is at edge N+COUNT.
  - `done` is high for the cycle after edge N+COUNT.
  - The earliest next `start` is accepted at edge N+COUNT+2 (after DONE returns to IDLE).
- No combinational path from `out_ready` to `out_valid`.
- `rst` asserted mid-burst returns all outputs to reset values immediately (asynchronously). No `done` is issued for the aborted burst.

## Structure
- Package `stim_pkg` holds:
  - `typedef logic [63:0] seed_t`.
  - State enum `stim_state_e` {IDLE, RUN, DONE}.
  - Function `xs64_advance(seed_t s, seed_t b)`, shared with the software-side reference model.
- One sub-module, `xs64_step`: combinational wrapper of `xs64_advance`, instantiated once.
- The top holds the FSM, count register (`$clog2(COUNT+1)` bits), state/increment registers and seed_after registers.

## Test plan
- Reset value check: assert `rst` with `start` high -> all outputs 0; `start` has no effect until `rst` deasserts.
- Basic burst (WIDTH=8, COUNT=4), `seed_a`=0, `seed_b`=0, `out_ready`=1:
  - vectors (val,unk) = (8'h00,0), (8'h01,0), (8'h42,0), ...
  - `done` one cycle after the 4th transfer.
  - `seed_after_b`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles on vector 2 -> `out_valid` stays 1 and `out_val`=8'h01 is stable. Release -> vector 3 (8'h42) appears on the next cycle.
- Replay: start a second burst with the `seed_after_a`/`seed_after_b` values from the first -> its vectors equal the software model's vectors 5..8 of one 8-vector burst.
- Ignored start: pulse `start` with different seeds during RUN and during DONE -> vector stream and burst length are unchanged.
- Mid-burst reset: assert `rst` after 2 transfers -> immediately `busy`=0 and `out_valid`=0, with no `done`. A subsequent `start` begins cleanly from the new seeds.

Source files
------------

// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stim_pkg
// Description : Shared types and the xorshift-plus-increment advance
//               function for the four-state stimulus generator. The same
//               advance function is used by the software reference model,
//               so any change here must be mirrored there.
// Contents    : seed_t, stim_state_e, xs64_advance()
// Revision    : 1.0 - initial release
// ============================================================================
package stim_pkg;

    localparam int C_SEED_W = 64;

    typedef logic [C_SEED_W-1:0] seed_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stim_state_e;

    // Xorshift scramble followed by an additive step. An odd increment makes
    // the map leave s=0, so the generator never locks up.
    function automatic seed_t xs64_advance(input seed_t s, input seed_t b);
        seed_t t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t + b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xs64_step.sv
`default_nettype none
// ============================================================================
// Module      : xs64_step
// Description : Combinational single-step generator advance.
// Ports       : s      in  64  current generator state
//               b      in  64  increment word (expected odd)
//               s_next out 64  advanced state
// Revision    : 1.0 - initial release
// ============================================================================
module xs64_step
    import stim_pkg::*;
(
    input  seed_t s,
    input  seed_t b,
    output seed_t s_next
);

    assign s_next = xs64_advance(s, b);

endmodule
`default_nettype wire

// File: rtl/four_state_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : four_state_stim_gen
// Description : Seeded burst source of 4-state vectors over valid/ready.
//               Each bit is (unk,val): 00=0, 01=1, 10=z, 11=x. A burst is
//               fully determined by (seed_a, seed_b); the ending state is
//               reported so bursts can be chained or replayed.
// Ports       : clk, rst                    clock, async active-high reset
//               start, seed_a, seed_b       burst request and seeds
//               out_valid, out_ready        output handshake
//               out_val, out_unk [WIDTH]    value / unknown planes
//               busy, done                  RUN indicator, end-of-burst pulse
//               seed_after_a, seed_after_b  state/increment after the burst
// Revision    : 1.0 - initial release
// ============================================================================
module four_state_stim_gen
    import stim_pkg::*;
#(
    parameter int WIDTH = 8,   // 1..16
    parameter int COUNT = 16   // >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      seed_a,
    input  logic [63:0]      seed_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [WIDTH-1:0] out_unk,
    output logic             busy,
    output logic             done,
    output logic [63:0]      seed_after_a,
    output logic [63:0]      seed_after_b
);

    localparam int               c_cnt_w = $clog2(COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(COUNT - 1);

    stim_state_e          r_state;
    seed_t                r_s;
    seed_t                r_b;
    logic [c_cnt_w-1:0]   r_count;
    seed_t                r_seed_after_a;
    seed_t                r_seed_after_b;
    seed_t                w_s_next;
    logic                 w_run;

    xs64_step u_step (
        .s      (r_s),
        .b      (r_b),
        .s_next (w_s_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_s            <= '0;
            r_b            <= 64'd1;
            r_count        <= '0;
            r_seed_after_a <= '0;
            r_seed_after_b <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_s     <= seed_a;
                        r_b     <= seed_b | 64'd1;
                        r_count <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // out_valid is constant-high in RUN, so out_ready alone
                    // qualifies the transfer.
                    if (out_ready) begin
                        r_s     <= w_s_next;
                        r_count <= r_count + c_cnt_w'(1);
                        if (r_count == c_last) begin
                            r_state        <= DONE;
                            r_seed_after_a <= w_s_next;
                            r_seed_after_b <= r_b;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; out_ready never reaches them
    // combinationally, and the planes cannot change while a transfer stalls.
    assign w_run        = (r_state == RUN);
    assign out_valid    = w_run;
    assign busy         = w_run;
    assign done         = (r_state == DONE);
    assign out_val      = w_run ? r_s[WIDTH-1:0] : '0;
    // AND of two independent fields gives about 25% unknown bits.
    assign out_unk      = w_run ? (r_s[32 +: WIDTH] & r_s[48 +: WIDTH]) : '0;
    assign seed_after_a = r_seed_after_a;
    assign seed_after_b = r_seed_after_b;

endmodule
`default_nettype wire

// File: tb/tb_four_state_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_state_stim_gen
// Description : Self-checking bench for four_state_stim_gen (WIDTH=8,
//               COUNT=4) with an independent reference model of the advance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_state_stim_gen;

    localparam int W = 8;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   seed_a;
    logic [63:0]   seed_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_val;
    logic [W-1:0]  out_unk;
    logic          busy;
    logic          done;
    logic [63:0]   seed_after_a;
    logic [63:0]   seed_after_b;

    int n_err = 0;
    int n_chk = 0;

    four_state_stim_gen #(.WIDTH(W), .COUNT(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed_a       (seed_a),
        .seed_b       (seed_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_val      (out_val),
        .out_unk      (out_unk),
        .busy         (busy),
        .done         (done),
        .seed_after_a (seed_after_a),
        .seed_after_b (seed_after_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] mdl_adv(input logic [63:0] s, input logic [63:0] b);
        logic [63:0] t;
        t = s ^ {s[50:0], 13'b0};
        t = t ^ {7'b0, t[63:7]};
        t = t ^ {t[46:0], 17'b0};
        return t + b;
    endfunction

    function automatic logic [7:0] mdl_unk(input logic [63:0] s);
        return s[39:32] & s[55:48];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 64'(out_valid), 64'd0);
        chk({tag, " busy"},  64'(busy),      64'd0);
        chk({tag, " done"},  64'(done),      64'd0);
        chk({tag, " val"},   64'(out_val),   64'd0);
        chk({tag, " unk"},   64'(out_unk),   64'd0);
    endtask

    // Full burst with out_ready high; optionally pulses start with other
    // seeds during RUN and DONE, which must change nothing.
    task automatic do_burst(input logic [63:0] sa, input logic [63:0] sb,
                            input bit junk_start, input string tag);
        logic [63:0] s;
        logic [63:0] b;
        s = sa;
        b = sb | 64'd1;
        seed_a    = sa;
        seed_b    = sb;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk({tag, " run valid"}, 64'(out_valid), 64'd1);
            chk({tag, " run busy"},  64'(busy),      64'd1);
            chk({tag, " run val"},   64'(out_val),   64'(s[7:0]));
            chk({tag, " run unk"},   64'(out_unk),   64'(mdl_unk(s)));
            if (junk_start) begin
                start  = 1'b1;
                seed_a = 64'hDEAD_BEEF_0000_0000 + 64'(i);
                seed_b = 64'h1234_5678_9ABC_DEF0;
            end
            step();
            start = 1'b0;
            s = mdl_adv(s, b);
        end
        chk({tag, " done pulse"},  64'(done),      64'd1);
        chk({tag, " done busy"},   64'(busy),      64'd0);
        chk({tag, " done valid"},  64'(out_valid), 64'd0);
        chk({tag, " seed_after_a"}, seed_after_a,  s);
        chk({tag, " seed_after_b"}, seed_after_b,  b);
        if (junk_start) begin
            start  = 1'b1;
            seed_a = 64'h5555_5555_5555_5555;
        end
        step();
        start = 1'b0;
        chk_idle({tag, " post-done"});
        step();
        chk_idle({tag, " idle"});
        chk({tag, " held seed_after_a"}, seed_after_a, s);
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       valid;
        logic       busy;
        logic       done;
        logic [7:0] val;
        logic [7:0] unk;
    } row_t;

    row_t        tbl [6];
    logic [63:0] ms [9];
    logic [63:0] sa_keep;
    logic [63:0] sb_keep;

    initial begin
        // Reference states for seed (0,0): ms[k] is the state for vector k.
        ms[0] = 64'd0;
        for (int k = 1; k < 9; k++) ms[k] = mdl_adv(ms[k-1], 64'd1);

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h42, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ms[3][7:0], mdl_unk(ms[3])};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

        // Reset with start held high: nothing may start.
        rst       = 1'b1;
        start     = 1'b1;
        seed_a    = 64'hFFFF_FFFF_FFFF_FFFF;
        seed_b    = 64'hAAAA_AAAA_AAAA_AAAA;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk_idle("reset");
        chk("reset seed_after_a", seed_after_a, 64'd0);
        chk("reset seed_after_b", seed_after_b, 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk_idle("after reset");

        // Basic burst, table driven.
        seed_a = 64'd0;
        seed_b = 64'd0;
        for (int r = 0; r < 6; r++) begin
            start     = tbl[r].start;
            out_ready = tbl[r].ready;
            step();
            chk($sformatf("tbl%0d valid", r), 64'(out_valid), 64'(tbl[r].valid));
            chk($sformatf("tbl%0d busy", r),  64'(busy),      64'(tbl[r].busy));
            chk($sformatf("tbl%0d done", r),  64'(done),      64'(tbl[r].done));
            chk($sformatf("tbl%0d val", r),   64'(out_val),   64'(tbl[r].val));
            chk($sformatf("tbl%0d unk", r),   64'(out_unk),   64'(tbl[r].unk));
        end
        start = 1'b0;
        chk("basic seed_after_a", seed_after_a, ms[4]);
        chk("basic seed_after_b", seed_after_b, 64'd1);

        // Replay: continuing from seed_after must yield vectors 5..8.
        sa_keep = seed_after_a;
        sb_keep = seed_after_b;
        seed_a  = sa_keep;
        seed_b  = sb_keep;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("replay v%0d valid", i + 5), 64'(out_valid), 64'd1);
            chk($sformatf("replay v%0d val", i + 5), 64'(out_val), 64'(ms[4+i][7:0]));
            chk($sformatf("replay v%0d unk", i + 5), 64'(out_unk), 64'(mdl_unk(ms[4+i])));
            step();
        end
        chk("replay done", 64'(done), 64'd1);
        chk("replay seed_after_a", seed_after_a, ms[8]);
        step();

        // Backpressure on vector 2.
        seed_a    = 64'd0;
        seed_b    = 64'd0;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("bp v1 val", 64'(out_val), 64'h00);
        step();
        out_ready = 1'b0;
        chk("bp v2 val", 64'(out_val), 64'h01);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp stall%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp stall%0d val", i),   64'(out_val),   64'h01);
            chk($sformatf("bp stall%0d done", i),  64'(done),      64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp v3 val", 64'(out_val), 64'h42);
        step();
        chk("bp v4 val", 64'(out_val), 64'(ms[3][7:0]));
        step();
        chk("bp done", 64'(done), 64'd1);
        chk("bp seed_after_a", seed_after_a, ms[4]);
        step();

        // Bursts with odd-forced increment and x/z-rich states, plus
        // ignored start pulses during RUN and DONE.
        do_burst(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, "seedA");
        do_burst(64'hFFFF_0000_FFFF_1234, 64'h0000_0000_0000_0002, 1'b1, "junk");

        // Mid-burst reset after two transfers.
        seed_a    = 64'd0;
        seed_b    = 64'd0;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre-abort val", 64'(out_val), 64'h42);
        rst = 1'b1;
        #1;
        chk("abort busy",  64'(busy),      64'd0);
        chk("abort valid", 64'(out_valid), 64'd0);
        chk("abort val",   64'(out_val),   64'd0);
        chk("abort seed_after_a", seed_after_a, 64'd0);
        step();
        step();
        rst = 1'b0;
        chk("abort no done", 64'(done), 64'd0);
        step();
        chk("abort idle done", 64'(done), 64'd0);
        do_burst(64'h8000_0000_0000_0001, 64'h7777_7777_7777_7777, 1'b0, "post-abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
